// File: rtl/gpio_bank.sv
// NUM_GPIO-pin GPIO bank with per-pin mode, atomic set/clear, input synchronisers
// and rising/falling edge interrupts with write-1-to-clear pending flags.
module gpio_bank #(
    parameter int NUM_GPIO    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [31:0]         wraddr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oe,
    output logic                irq
);

    typedef enum logic [2:0] {
        REG_CTRL = 3'd0,
        REG_DATA = 3'd1,
        REG_SET  = 3'd2,
        REG_CLR  = 3'd3,
        REG_IEN  = 3'd4,
        REG_RISE = 3'd5,
        REG_FALL = 3'd6,
        REG_PEND = 3'd7
    } reg_e;

    logic [2*NUM_GPIO-1:0] ctrl;
    logic [NUM_GPIO-1:0]   out_q, ien, rise_en, fall_en, pend, prev;
    logic [NUM_GPIO-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_GPIO-1:0]   sync, is_out, is_in, edges, w1c;
    logic                  mapped, wr_en;
    reg_e                  reg_idx;
    logic                  unused_bits;

    assign mapped      = (wraddr[1:0] == 2'b00);
    assign wr_en       = we && mapped;
    assign reg_idx     = reg_e'(wraddr[4:2]);
    assign unused_bits = ^{wraddr[31:5], wdata};

    always_comb begin
        is_out = '0;
        is_in  = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            is_out[i] = (ctrl[2*i +: 2] == 2'b01);
            is_in[i]  = (ctrl[2*i +: 2] == 2'b10);
        end
    end

    // prev follows sync in every mode, so entering input mode never sees a stale edge
    assign sync  = sync_q[SYNC_STAGES-1];
    assign edges = is_in & ((sync & ~prev & rise_en) | (~sync & prev & fall_en));
    assign w1c   = (wr_en && reg_idx == REG_PEND) ? wdata[NUM_GPIO-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl    <= '0;
            out_q   <= '0;
            ien     <= '0;
            rise_en <= '0;
            fall_en <= '0;
            pend    <= '0;
            prev    <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev <= sync;
            pend <= (pend & ~w1c) | edges;
            if (wr_en) begin
                case (reg_idx)
                    REG_CTRL: ctrl    <= wdata[2*NUM_GPIO-1:0];
                    REG_DATA: out_q   <= wdata[NUM_GPIO-1:0];
                    REG_SET:  out_q   <= out_q | wdata[NUM_GPIO-1:0];
                    REG_CLR:  out_q   <= out_q & ~wdata[NUM_GPIO-1:0];
                    REG_IEN:  ien     <= wdata[NUM_GPIO-1:0];
                    REG_RISE: rise_en <= wdata[NUM_GPIO-1:0];
                    REG_FALL: fall_en <= wdata[NUM_GPIO-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (!rst && mapped) begin
            case (reg_idx)
                REG_CTRL: rdata = 32'(ctrl);
                REG_DATA: rdata = 32'((out_q & is_out) | (sync & is_in));
                REG_IEN:  rdata = 32'(ien);
                REG_RISE: rdata = 32'(rise_en);
                REG_FALL: rdata = 32'(fall_en);
                REG_PEND: rdata = 32'(pend);
                default:  rdata = '0;
            endcase
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = is_out;
    assign irq      = |(pend & ien);

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: directed register/interrupt scenarios with literal expectations,
// then randomized traffic compared every cycle against a per-pin behavioural model.
module tb_gpio_bank;

    localparam int NG = 2;
    localparam int SS = 2;

    logic          clk;
    logic          rst;
    logic          we;
    logic [31:0]   wraddr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [NG-1:0] gpio_in;
    logic [NG-1:0] gpio_out;
    logic [NG-1:0] gpio_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;

    gpio_bank #(.NUM_GPIO(NG), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wraddr   (wraddr),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: one entry per pin; pad history holds raw samples, newest first
    int            m_mode [NG];
    bit            m_out  [NG];
    bit            m_ien  [NG];
    bit            m_rise [NG];
    bit            m_fall [NG];
    bit            m_pend [NG];
    bit            m_prev [NG];
    logic [NG-1:0] hist [$];
    bit            model_valid = 1'b0;

    always @(posedge clk) begin
        logic [NG-1:0] s;
        bit            hit;
        if (rst) begin
            for (int i = 0; i < NG; i++) begin
                m_mode[i] = 0; m_out[i] = 0; m_ien[i] = 0; m_rise[i] = 0;
                m_fall[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
            end
            hist = {};
            for (int k = 0; k < SS; k++) hist.push_back('0);
            model_valid = 1'b1;
        end else if (model_valid) begin
            s = hist[SS-1];
            for (int i = 0; i < NG; i++) begin
                hit = (m_mode[i] == 2) &&
                      ((s[i] && !m_prev[i] && m_rise[i]) || (!s[i] && m_prev[i] && m_fall[i]));
                if (hit) m_pend[i] = 1;
                else if (we && wraddr[4:0] == 5'h1C && wdata[i]) m_pend[i] = 0;
            end
            if (we && wraddr[1:0] == 2'b00) begin
                for (int i = 0; i < NG; i++) begin
                    case (wraddr[4:2])
                        3'd0: m_mode[i] = int'(wdata[2*i +: 2]);
                        3'd1: m_out[i]  = wdata[i];
                        3'd2: if (wdata[i]) m_out[i] = 1;
                        3'd3: if (wdata[i]) m_out[i] = 0;
                        3'd4: m_ien[i]  = wdata[i];
                        3'd5: m_rise[i] = wdata[i];
                        3'd6: m_fall[i] = wdata[i];
                        default: ;
                    endcase
                end
            end
            for (int i = 0; i < NG; i++) m_prev[i] = s[i];
            hist.push_front(gpio_in);
            void'(hist.pop_back());
        end
    end

    function automatic logic [31:0] readModel(input logic [31:0] a, input logic r);
        logic [31:0]   v;
        logic [NG-1:0] s;
        v = '0;
        s = hist[SS-1];
        for (int i = 0; i < NG; i++) begin
            case (a[4:2])
                3'd0: v[2*i +: 2] = 2'(m_mode[i]);
                3'd1: v[i] = (m_mode[i] == 1) ? m_out[i] : ((m_mode[i] == 2) ? s[i] : 1'b0);
                3'd4: v[i] = m_ien[i];
                3'd5: v[i] = m_rise[i];
                3'd6: v[i] = m_fall[i];
                3'd7: v[i] = m_pend[i];
                default: ;
            endcase
        end
        if (r || a[1:0] != 2'b00) v = '0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [NG-1:0] e_out, e_oe;
        bit            e_irq;
        if (model_valid) begin
            e_irq = 0;
            for (int i = 0; i < NG; i++) begin
                e_out[i] = m_out[i];
                e_oe[i]  = (m_mode[i] == 1);
                if (m_pend[i] && m_ien[i]) e_irq = 1;
            end
            checkOutput("gpio_out", 32'(gpio_out), 32'(e_out));
            checkOutput("gpio_oe", 32'(gpio_oe), 32'(e_oe));
            checkOutput("irq", 32'(irq), 32'(e_irq));
            checkOutput("rdata", rdata, readModel(wraddr, rst));
        end
    end

    // Callers sit just after a rising edge; the write lands on the next edge
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; wraddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
        wraddr = a;
        #1;
        checkOutput(name, rdata, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  idx;
        logic [1:0]  low;
        logic [NG-1:0] flip;

        rst = 1'b1; we = 1'b0; wraddr = '0; wdata = '0; gpio_in = '0;
        idle(2);
        readCheck("rdata_in_reset", 32'h1C, 32'h0);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) readCheck("reset_read", 32'(k * 4), 32'h0);
        checkOutput("reset_oe", 32'(gpio_oe), 32'h0);
        checkOutput("reset_out", 32'(gpio_out), 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);

        applyStimulus(32'h00, 32'h5);
        applyStimulus(32'h04, 32'h1);
        checkOutput("data_out", 32'(gpio_out), 32'h1);
        checkOutput("oe_both", 32'(gpio_oe), 32'h3);
        applyStimulus(32'h08, 32'h2);
        checkOutput("set_out", 32'(gpio_out), 32'h3);
        applyStimulus(32'h0C, 32'h1);
        checkOutput("clr_out", 32'(gpio_out), 32'h2);
        readCheck("data_read", 32'h04, 32'h2);

        applyStimulus(32'h00, 32'h6);
        applyStimulus(32'h14, 32'h1);
        applyStimulus(32'h10, 32'h1);
        gpio_in = 2'b01;
        idle(2);
        checkOutput("irq_before_3", 32'(irq), 32'h0);
        idle(1);
        checkOutput("irq_at_3", 32'(irq), 32'h1);
        readCheck("pend_rise", 32'h1C, 32'h1);

        applyStimulus(32'h18, 32'h1);
        gpio_in = 2'b00;
        idle(2);
        applyStimulus(32'h1C, 32'h1);
        readCheck("pend_set_wins", 32'h1C, 32'h1);
        applyStimulus(32'h1C, 32'h1);
        readCheck("pend_cleared", 32'h1C, 32'h0);
        checkOutput("irq_cleared", 32'(irq), 32'h0);

        applyStimulus(32'h10, 32'h0);
        applyStimulus(32'h00, 32'hA);
        applyStimulus(32'h14, 32'h3);
        gpio_in = 2'b10;
        idle(3);
        readCheck("pend_pin1", 32'h1C, 32'h2);
        checkOutput("irq_masked", 32'(irq), 32'h0);
        applyStimulus(32'h10, 32'h2);
        checkOutput("irq_unmasked", 32'(irq), 32'h1);

        applyStimulus(32'h14, 32'hFFFF_FFFF);
        readCheck("rise_masked", 32'h14, 32'h3);
        readCheck("wrap_ctrl", 32'h20, 32'hA);
        readCheck("data_input", 32'h04, 32'h2);
        readCheck("unmapped_rd", 32'h02, 32'h0);
        applyStimulus(32'h05, 32'h0);
        readCheck("unmapped_wr", 32'h00, 32'hA);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            we  = $urandom_range(0, 1) == 1;
            idx = 3'($urandom_range(0, 7));
            low = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r   = $urandom();
            wraddr = {(($urandom_range(0, 3) == 0) ? r[31:5] : 27'h0), idx, low};
            wdata  = $urandom();
            for (int i = 0; i < NG; i++) flip[i] = ($urandom_range(0, 3) == 0);
            gpio_in = gpio_in ^ flip;
            @(posedge clk); #1;
        end

        rst = 1'b0; we = 1'b0;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
